rhythm_lanes: RTL and testbench
===============================

Name: rhythm_lanes

Overview:
Parametrised falling-note rhythm-game core: N lanes, LFSR note spawning, debounced edge-triggered hit judging, BCD score, combo counter and registered VGA pixel colour.
- Successor to the fixed 4-lane game: adds lane count, window and geometry parameters, press edge detection, combo tracking, miss reporting and 4-digit BCD score.
- Sits between vga_gen (supplies row/col) and the sevenseg drivers.

Parameters:
LANES, 4, number of lanes (1..8)
LANE_W, 160, lane width in pixels
TICK_DIV, 2500000, clk cycles per game tick
HIT_LO, 350, lowest note position accepted as a hit
HIT_HI, 500, position at or beyond which a note is missed
NOTE_LEN, 70, note height in rows
LFSR_SEED, 20'd123456, non-zero LFSR reset value

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
btn  in  LANES  lane buttons, active-low, asynchronous
speed  in  4  rows advanced per tick; 0 freezes notes
row  in  10  current pixel row
col  in  10  current pixel column
r  out  8  red
g  out  8  green
b  out  8  blue
score_bcd  out  16  four BCD digits, ones in [3:0]
combo  out  8  consecutive hits, saturating at 255
hit_pulse  out  1  one-cycle pulse on the tick where at least one hit occurs
miss_pulse  out  1  one-cycle pulse on the tick where at least one miss occurs

Behaviour:
- Reset, asynchronous, reset low: all positions 0 (lane empty), LFSR=LFSR_SEED, tick counter 0, score_bcd=0, combo=0, pulses 0, r=g=b=0, pending presses cleared.
- btn: 2-FF synchroniser per lane, then falling-edge detect. A press sets pending[i]; pending is held until the next tick, then cleared.
- Tick:
  - Counter counts 0..TICK_DIV-1.
  - Tick fires on the cycle the counter equals TICK_DIV-1; the counter wraps to 0 on that cycle.
  - All lane updates below happen on the tick cycle only.
- LFSR: 20-bit Fibonacci, shifts every clk cycle; new bit = lfsr[19]^lfsr[16].
- Per lane i with pos[i]!=0, evaluated in priority order:
  1. Hit: pending[i] and pos[i]>=HIT_LO -> pos[i]=0; score +1; combo +1.
  2. Miss: otherwise, if pos[i]+speed>=HIT_HI -> pos[i]=0; combo=0.
  3. Otherwise pos[i]+=speed, computed at 11 bits with no wrap.
- Score and combo arithmetic:
  - k simultaneous hits on one tick add k to score; combo adds k.
  - A miss on the same tick as any hit forces combo to 0 (miss wins).
  - Score saturates at 9999 BCD; combo saturates at 255.
- Pending press on an empty lane, or on a note with pos<HIT_LO: ignored (see optional feature).
- Spawn: on tick, sel=lfsr[3:0]. If sel<LANES, pos[sel]==0 at the start of the tick, and lane sel had no hit/miss this tick -> pos[sel]=1. At most one spawn per tick.
- Pixel path, registered, 1 clk latency from row/col; defaults r=g=b=0; lane=col/LANE_W, x=col%LANE_W; first matching rule wins:
  - lane>=LANES: black
  - x<=20 or x>=LANE_W-20: b=100
  - HIT_LO+NOTE_LEN<=row<=HIT_LO+NOTE_LEN+10: g=100
  - pos[lane]!=0 and pos[lane]<=row<pos[lane]+NOTE_LEN: r=100
- hit_pulse and miss_pulse are registered and high for exactly the clk cycle after the tick.
- Reset mid-game: all state returns immediately to reset values; the first tick occurs TICK_DIV cycles after reset release.

Optional Feature:
- Macro MISS_PENALTY_EN, when defined: a pending press consumed on a tick where lane i has no hittable note (empty or pos<HIT_LO) sets combo=0, decrements score by 1 (saturating at 0) and asserts miss_pulse.
- When undefined: such presses are silently discarded.

Test Plan:
- Reset low mid-game with score 0042, combo 7 -> score_bcd=0x0000, combo=0, all lanes empty, rgb 0 on next cycle.
- TICK_DIV=4, speed=10, force spawn lane 2 (pos=1), press btn[2] when pos=351 -> on that tick pos[2]=0, score_bcd=0x0001, combo=1, hit_pulse for 1 cycle.
- Note at pos=491, speed=10, no press -> pos cleared, combo 5->0, miss_pulse=1, score unchanged.
- Hits in lanes 0 and 3 on the same tick with score 9998 -> score_bcd=0x9999 (saturated), combo +2.
- btn[1] held low across 3 ticks with a note entering the window after the first tick -> only the first edge is registered; since it is consumed on a tick with pos<HIT_LO, no hit. With MISS_PENALTY_EN: combo=0 and score-1.
- row=425, col=80 -> g=100 after 1 cycle; col=650 with LANES=4 -> rgb 0; col=10 -> b=100.

Source files
------------

// File: rtl/rhythm_lanes.sv
// rtl/rhythm_lanes.sv - N-lane falling-note rhythm core; optional MISS_PENALTY_EN
module rhythm_lanes #(
   parameter int          LANES     = 4,
   parameter int          LANE_W    = 160,
   parameter int          TICK_DIV  = 2500000,
   parameter int          HIT_LO    = 350,
   parameter int          HIT_HI    = 500,
   parameter int          NOTE_LEN  = 70,
   parameter logic [19:0] LFSR_SEED = 20'd123456
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LANES-1:0] btn,
   input  logic [3:0]       speed,
   input  logic [9:0]       row,
   input  logic [9:0]       col,
   output logic [7:0]       r,
   output logic [7:0]       g,
   output logic [7:0]       b,
   output logic [15:0]      score_bcd,
   output logic [7:0]       combo,
   output logic             hit_pulse,
   output logic             miss_pulse
);

   localparam int CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GREEN_LO  = HIT_LO + NOTE_LEN;
   localparam int GREEN_HI  = GREEN_LO + 10;
   localparam int SCORE_MAX = 9999;

   logic [LANES-1:0] btn_s1, btn_s2, btn_prev;
   logic [LANES-1:0] press, pending, pend_eff;
   logic [CW-1:0]    tick_cnt;
   logic             tick;
   logic [19:0]      lfsr;
   logic [10:0]      pos     [LANES];
   logic [10:0]      pos_nxt [LANES];
   logic [10:0]      step;
   logic [LANES-1:0] hit_v, miss_v;
   logic [3:0]       hit_cnt;
   logic             any_miss;
   logic [13:0]      score;
   logic [13:0]      score_nxt;
   logic [15:0]      score_sum;
   logic [8:0]       combo_sum;
   logic [7:0]       combo_nxt;
   logic [9:0]       px_lane, px_x;
   logic [10:0]      px_pos;
   logic [10:0]      row_w;

   // Buttons idle high, so the synchroniser resets to 1 to avoid a phantom edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_s1   <= '1;
         btn_s2   <= '1;
         btn_prev <= '1;
      end else begin
         btn_s1   <= btn;
         btn_s2   <= btn_s1;
         btn_prev <= btn_s2;
      end
   end

   assign press    = btn_prev & ~btn_s2;
   // A press landing on the tick cycle itself is judged on that tick
   assign pend_eff = pending | press;

   // Pending presses accumulate between ticks and are consumed by each tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    pending <= '0;
      else if (tick) pending <= '0;
      else           pending <= pending | press;
   end

   assign tick = (tick_cnt == CW'(TICK_DIV - 1));

   // Game tick divider, wraps on the tick cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   // Free-running spawn LFSR (x^20 + x^17 + 1)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) lfsr <= LFSR_SEED;
      else        lfsr <= {lfsr[18:0], lfsr[19] ^ lfsr[16]};
   end

   // Per-lane judging (hit before miss before advance) and single-lane spawn
   always_comb begin
      hit_v  = '0;
      miss_v = '0;
      step   = '0;
      for (int i = 0; i < LANES; i++) begin
         pos_nxt[i] = pos[i];
         step       = pos[i] + 11'(speed);
         if (pos[i] != '0) begin
            if (pend_eff[i] && (pos[i] >= 11'(HIT_LO))) begin
               hit_v[i]   = 1'b1;
               pos_nxt[i] = '0;
            end else if (step >= 11'(HIT_HI)) begin
               miss_v[i]  = 1'b1;
               pos_nxt[i] = '0;
            end else begin
               pos_nxt[i] = step;
            end
         end
         // An empty lane cannot have been judged, so emptiness alone gates spawn
         if ((4'(i) == lfsr[3:0]) && (pos[i] == '0))
            pos_nxt[i] = 11'd1;
      end
   end

`ifdef MISS_PENALTY_EN
   logic [LANES-1:0] pen_v;
   logic [3:0]       pen_cnt;

   // Presses that found nothing hittable in their lane
   always_comb begin
      pen_v   = '0;
      pen_cnt = '0;
      for (int i = 0; i < LANES; i++) begin
         pen_v[i] = pend_eff[i] && (pos[i] < 11'(HIT_LO));
         pen_cnt  = pen_cnt + 4'(pen_v[i]);
      end
   end
`endif

   // Tick totals: net score change clamped to 0..9999, combo reset by any miss
   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < LANES; i++)
         hit_cnt = hit_cnt + 4'(hit_v[i]);
      score_sum = {2'b00, score} + {12'd0, hit_cnt};
`ifdef MISS_PENALTY_EN
      any_miss = (|miss_v) | (|pen_v);
      if (score_sum < {12'd0, pen_cnt}) score_sum = '0;
      else                              score_sum = score_sum - {12'd0, pen_cnt};
`else
      any_miss = |miss_v;
`endif
      if (score_sum > 16'(SCORE_MAX)) score_nxt = 14'(SCORE_MAX);
      else                            score_nxt = score_sum[13:0];
      combo_sum = {1'b0, combo} + {5'd0, hit_cnt};
      if (any_miss)               combo_nxt = '0;
      else if (combo_sum > 9'd255) combo_nxt = 8'd255;
      else                         combo_nxt = combo_sum[7:0];
   end

   // Game state advances only on the tick; pulses mark the cycle after it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LANES; i++) pos[i] <= '0;
         score      <= '0;
         combo      <= '0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end else begin
         hit_pulse  <= tick & (|hit_v);
         miss_pulse <= tick & any_miss;
         if (tick) begin
            for (int i = 0; i < LANES; i++) pos[i] <= pos_nxt[i];
            score <= score_nxt;
            combo <= combo_nxt;
         end
      end
   end

   function automatic logic [15:0] to_bcd(input logic [13:0] v);
      logic [29:0] sh;
      sh = {16'd0, v};
      for (int k = 0; k < 14; k++) begin
         for (int d = 0; d < 4; d++)
            if (sh[14+4*d +: 4] >= 4'd5) sh[14+4*d +: 4] = sh[14+4*d +: 4] + 4'd3;
         sh = sh << 1;
      end
      return sh[29:14];
   endfunction

   assign score_bcd = to_bcd(score);

   // Pixel lookup: which lane and where inside it, plus that lane's note position
   always_comb begin
      px_lane = col / 10'(LANE_W);
      px_x    = col % 10'(LANE_W);
      row_w   = {1'b0, row};
      px_pos  = '0;
      for (int i = 0; i < LANES; i++)
         if (px_lane == 10'(i)) px_pos = pos[i];
   end

   // Registered colour, first matching rule wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r <= '0;
         g <= '0;
         b <= '0;
      end else begin
         r <= '0;
         g <= '0;
         b <= '0;
         if (px_lane >= 10'(LANES)) begin
            r <= '0;
         end else if ((px_x <= 10'd20) || (px_x >= 10'(LANE_W - 20))) begin
            b <= 8'd100;
         end else if ((row_w >= 11'(GREEN_LO)) && (row_w <= 11'(GREEN_HI))) begin
            g <= 8'd100;
         end else if ((px_pos != '0) && (px_pos <= row_w) &&
                      (row_w < px_pos + 11'(NOTE_LEN))) begin
            r <= 8'd100;
         end
      end
   end

endmodule

// File: tb/tb_rhythm_lanes.sv
// tb/tb_rhythm_lanes.sv - table, directed and randomized checks of rhythm_lanes against a reference model
module tb_rhythm_lanes;

   localparam int LN  = 4;
   localparam int TD  = 4;
   localparam int HLO = 350;
   localparam int HHI = 500;
   localparam int NL  = 70;
   localparam int LW  = 160;
   localparam logic [19:0] SEED = 20'd123456;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  btn;
   logic [3:0]  speed;
   logic [9:0]  row, col;
   logic [7:0]  r, g, b;
   logic [15:0] score_bcd;
   logic [7:0]  combo;
   logic        hit_pulse, miss_pulse;

   logic [7:0]  btn2;
   logic [3:0]  speed2;
   logic [9:0]  row2, col2;
   logic [7:0]  s_r, s_g, s_b;
   logic [15:0] s_score;
   logic [7:0]  s_combo;
   logic        s_hit, s_miss;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rhythm_lanes #(.LANES(LN), .LANE_W(LW), .TICK_DIV(TD), .HIT_LO(HLO), .HIT_HI(HHI),
                  .NOTE_LEN(NL), .LFSR_SEED(SEED)) u_dut (
      .clk(clk), .reset(reset), .btn(btn), .speed(speed), .row(row), .col(col),
      .r(r), .g(g), .b(b), .score_bcd(score_bcd), .combo(combo),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse));

   // Frozen single-row-hittable notes to drive the score into saturation quickly
   rhythm_lanes #(.LANES(8), .LANE_W(80), .TICK_DIV(1), .HIT_LO(1), .HIT_HI(500),
                  .NOTE_LEN(70), .LFSR_SEED(SEED)) u_sat (
      .clk(clk), .reset(reset), .btn(btn2), .speed(speed2), .row(row2), .col(col2),
      .r(s_r), .g(s_g), .b(s_b), .score_bcd(s_score), .combo(s_combo),
      .hit_pulse(s_hit), .miss_pulse(s_miss));

   // Reference model state
   int          m_pos [LN];
   int          m_score, m_combo, m_cyc;
   int          m_r, m_g, m_b;
   bit          m_hit_p, m_miss_p, m_last_tick;
   logic [3:0]  m_pend;
   logic [19:0] m_lfsr;
   logic [3:0]  bhist [$];

   typedef struct {
      logic [9:0] row;
      logic [9:0] col;
      logic [7:0] er, eg, eb;
   } pix_vec_t;

   function automatic logic [15:0] bcd(input int v);
      logic [3:0] d0, d1, d2, d3;
      d0 = 4'(v % 10);
      d1 = 4'((v / 10) % 10);
      d2 = 4'((v / 100) % 10);
      d3 = 4'((v / 1000) % 10);
      return {d3, d2, d1, d0};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < LN; i++) m_pos[i] = 0;
      m_score = 0; m_combo = 0; m_cyc = 0;
      m_r = 0; m_g = 0; m_b = 0;
      m_hit_p = 0; m_miss_p = 0; m_last_tick = 0;
      m_pend = '0;
      m_lfsr = SEED;
      bhist.delete();
      repeat (3) bhist.push_back(4'hF);
   endtask

   task automatic model_step();
      int lane, x, sel, hits, misses, pens, net;
      int start [LN];
      logic [3:0] edge_v;
      bit tk, pe;
      lane = int'(col) / LW;
      x    = int'(col) % LW;
      m_r = 0; m_g = 0; m_b = 0;
      if (lane >= LN) ;
      else if (x <= 20 || x >= LW - 20) m_b = 100;
      else if (int'(row) >= HLO + NL && int'(row) <= HLO + NL + 10) m_g = 100;
      else if (m_pos[lane] != 0 && m_pos[lane] <= int'(row) && int'(row) < m_pos[lane] + NL) m_r = 100;
      edge_v = bhist[0] & ~bhist[1];
      void'(bhist.pop_front());
      bhist.push_back(btn);
      tk = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      m_last_tick = tk;
      sel = int'(m_lfsr[3:0]);
      m_hit_p = 0; m_miss_p = 0;
      if (tk) begin
         hits = 0; misses = 0; pens = 0;
         for (int i = 0; i < LN; i++) start[i] = m_pos[i];
         for (int i = 0; i < LN; i++) begin
            pe = m_pend[i] | edge_v[i];
            if (start[i] != 0 && pe && start[i] >= HLO) begin
               m_pos[i] = 0; hits++;
            end else if (start[i] != 0 && start[i] + int'(speed) >= HHI) begin
               m_pos[i] = 0; misses++;
            end else if (start[i] != 0) begin
               m_pos[i] = start[i] + int'(speed);
            end
`ifdef MISS_PENALTY_EN
            if (pe && start[i] < HLO) pens++;
`endif
         end
         if (sel < LN) if (start[sel] == 0) m_pos[sel] = 1;
         net = m_score + hits - pens;
         m_score = (net < 0) ? 0 : ((net > 9999) ? 9999 : net);
         if (misses > 0 || pens > 0) m_combo = 0;
         else m_combo = (m_combo + hits > 255) ? 255 : m_combo + hits;
         m_hit_p  = (hits > 0);
         m_miss_p = (misses > 0 || pens > 0);
         m_pend = '0;
      end else begin
         m_pend = m_pend | edge_v;
      end
      m_lfsr = {m_lfsr[18:0], m_lfsr[19] ^ m_lfsr[16]};
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic check_outputs();
      vectors++;
      if (score_bcd !== bcd(m_score) || combo !== 8'(m_combo) || hit_pulse !== m_hit_p ||
          miss_pulse !== m_miss_p || r !== 8'(m_r) || g !== 8'(m_g) || b !== 8'(m_b)) begin
         miscompares++;
         $display("FAIL model t=%0t: got score %h combo %0d hit %b miss %b rgb %0d,%0d,%0d want score %h combo %0d hit %b miss %b rgb %0d,%0d,%0d",
                  $time, score_bcd, combo, hit_pulse, miss_pulse, r, g, b,
                  bcd(m_score), m_combo, m_hit_p, m_miss_p, m_r, m_g, m_b);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!reset) model_reset();
      else        model_step();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      pix_vec_t pix [14];
      int n, sb, ticks;

      pix[0]  = '{10'd425, 10'd80,  8'd0,   8'd100, 8'd0};
      pix[1]  = '{10'd425, 10'd650, 8'd0,   8'd0,   8'd0};
      pix[2]  = '{10'd200, 10'd10,  8'd0,   8'd0,   8'd100};
      pix[3]  = '{10'd200, 10'd80,  8'd0,   8'd0,   8'd0};
      pix[4]  = '{10'd420, 10'd80,  8'd0,   8'd100, 8'd0};
      pix[5]  = '{10'd430, 10'd80,  8'd0,   8'd100, 8'd0};
      pix[6]  = '{10'd431, 10'd80,  8'd0,   8'd0,   8'd0};
      pix[7]  = '{10'd419, 10'd80,  8'd0,   8'd0,   8'd0};
      pix[8]  = '{10'd200, 10'd140, 8'd0,   8'd0,   8'd100};
      pix[9]  = '{10'd200, 10'd139, 8'd0,   8'd0,   8'd0};
      pix[10] = '{10'd200, 10'd20,  8'd0,   8'd0,   8'd100};
      pix[11] = '{10'd200, 10'd21,  8'd0,   8'd0,   8'd0};
      pix[12] = '{10'd425, 10'd160, 8'd0,   8'd0,   8'd100};
      pix[13] = '{10'd425, 10'd640, 8'd0,   8'd0,   8'd0};

      reset = 1'b0; btn = 4'hF; speed = 4'd0; row = '0; col = '0;
      btn2 = 8'hFF; speed2 = 4'd0; row2 = '0; col2 = '0;
      model_reset();
      @(negedge clk);
      check("reset_score", 32'(score_bcd), 32'h0000);
      check("reset_combo", 32'(combo), 32'd0);
      check("reset_rgb", {8'd0, r, g, b}, 32'd0);
      cycle();
      reset = 1'b1;

      // Pixel table with notes frozen near the top
      foreach (pix[i]) begin
         row = pix[i].row; col = pix[i].col;
         cycle();
         check($sformatf("pix%0d", i), {8'd0, r, g, b}, {8'd0, pix[i].er, pix[i].eg, pix[i].eb});
      end
      row = 10'd0; col = 10'd0;

      // Hit a lane-2 note right as it reaches 351
      speed = 4'd10;
      n = 0;
      do begin cycle(); n++; end while (!(m_last_tick && m_pos[2] == 351) && n < 8000);
      check("wait_lane2_351", 32'(n < 8000), 32'd1);
      sb = m_score;
      btn[2] = 1'b0;
      n = 0;
      do begin cycle(); n++; end while (!m_last_tick && n < 8);
      check("hit_pulse", 32'(hit_pulse), 32'd1);
      check("hit_score", 32'(score_bcd), 32'(bcd(sb + 1)));
      btn[2] = 1'b1;
      cycle();
      check("hit_pulse_one_cycle", 32'(hit_pulse), 32'd0);

      // Let a note run off the bottom unpressed
      n = 0;
      do begin cycle(); n++; end
      while (!(m_last_tick && (m_pos[0] == 491 || m_pos[1] == 491 || m_pos[2] == 491 || m_pos[3] == 491)) && n < 8000);
      check("wait_pos491", 32'(n < 8000), 32'd1);
      sb = m_score;
      n = 0;
      do begin cycle(); n++; end while (!m_last_tick && n < 8);
      check("miss_pulse", 32'(miss_pulse), 32'd1);
      check("miss_combo", 32'(combo), 32'd0);
      check("miss_score", 32'(score_bcd), 32'(bcd(sb)));

      // Held button: one edge, consumed before the note is hittable
      n = 0;
      do begin cycle(); n++; end while (!(m_last_tick && m_pos[1] == 341) && n < 8000);
      check("wait_lane1_341", 32'(n < 8000), 32'd1);
      sb = m_score;
      btn[1] = 1'b0;
      ticks = 0; n = 0;
      while (ticks < 3 && n < 20) begin
         cycle(); n++;
         if (m_last_tick) begin
            ticks++;
            check($sformatf("held_no_hit%0d", ticks), 32'(hit_pulse), 32'd0);
         end
      end
`ifndef MISS_PENALTY_EN
      check("held_score", 32'(score_bcd), 32'(bcd(sb)));
`endif
      btn[1] = 1'b1;

      // Randomized play against the model
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) speed = 4'($urandom_range(15, 5));
         for (int k = 0; k < LN; k++)
            if ($urandom_range(7) == 0) btn[k] = ~btn[k];
         row = 10'($urandom_range(1023));
         col = 10'($urandom_range(1023));
         cycle();
      end

      // Reset mid-game
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midreset_score", 32'(score_bcd), 32'h0000);
      check("midreset_combo", 32'(combo), 32'd0);
      check("midreset_pulses", {30'd0, hit_pulse, miss_pulse}, 32'd0);
      check("midreset_rgb", {8'd0, r, g, b}, 32'd0);
      btn = 4'hF; speed = 4'd0; row = '0; col = '0;
      cycle();
      reset = 1'b1;
      check("sat_reset_score", 32'(s_score), 32'h0000);

      // Saturation: frozen notes hit continuously
      n = 0;
      while (s_score !== 16'h9999 && n < 60000) begin
         btn2 = ~btn2;
         cycle();
         n++;
      end
      check("sat_reach_9999", 32'(n < 60000), 32'd1);
      repeat (200) begin
         btn2 = ~btn2;
         cycle();
      end
      check("sat_hold_9999", 32'(s_score), 32'h9999);
      check("sat_combo_255", 32'(s_combo), 32'd255);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
